// File: rtl/hd_data_gen_pkg.sv
// rtl/hd_data_gen_pkg.sv - shared hd parameters, encodings and LFSR step
package hd_data_gen_pkg;

  localparam int HD_K       = 4;
  localparam int HD_DEC_LAT = 3;
  localparam int HD_LFSR_W  = 16;

  // Galois tap mask for x^16+x^14+x^13+x^11+1 in right-shifting form
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_FIXED = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/hd_dly_line.sv
// rtl/hd_dly_line.sv - fixed-latency shift register with zero-depth bypass
module hd_dly_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_sr
      logic [W-1:0] sr [DEPTH];

      // Shift every cycle regardless of content so the latency never varies.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
          sr[0] <= d;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/hd_data_gen.sv
// rtl/hd_data_gen.sv - paced data-word source with latency-matched copy for the checker
module hd_data_gen
  import hd_data_gen_pkg::*;
#(
  parameter int                k         = HD_K,
  parameter int                DEC_LAT   = HD_DEC_LAT,
  parameter int                LFSR_W    = HD_LFSR_W,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
  parameter int                NUM_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [k-1:0] pattern,
  input  logic [3:0]   gap,
  output logic [k-1:0] dout,
  output logic         dvld,
  output logic [k-1:0] din_d,
  output logic         dvld_d,
  output logic         busy,
  output logic         done,
  output logic [15:0]  word_cnt
);

  localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam int                DRAIN_LEN = (DEC_LAT == 0) ? 1 : DEC_LAT;
  localparam logic [15:0]       LAST_CNT  = 16'(NUM_WORDS);
  localparam bit                LIMITED   = (NUM_WORDS != 0);

  state_t             state_q;
  mode_t              mode_q;
  logic [k-1:0]       pat_q;
  logic [3:0]         gap_q;
  logic [k-1:0]       inc_q;
  logic [k-1:0]       walk_q;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [15:0]        tmr_q;

  logic               start_ok;
  logic               last_word;
  logic               emit;
  mode_t              g_mode;
  logic [k-1:0]       g_pat;
  logic [k-1:0]       g_inc;
  logic [k-1:0]       g_walk;
  logic [LFSR_W-1:0]  g_lfsr;
  logic [k-1:0]       word;
  logic [k:0]         dly_q;

  assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_word = LIMITED && (word_cnt == LAST_CNT);

  // Decide whether a word goes out next cycle; a start sees the freshly reinitialised generator.
  always_comb begin
    emit   = start_ok
          || (state_q == ST_RUN && !last_word && gap_q == 4'd0)
          || (state_q == ST_GAP && tmr_q == 16'd1);
    g_mode = start_ok ? mode_t'(mode) : mode_q;
    g_pat  = start_ok ? pattern : pat_q;
    g_inc  = start_ok ? '0 : inc_q;
    g_walk = start_ok ? k'(1) : walk_q;
    g_lfsr = start_ok ? SEED_EFF : lfsr_q;
    case (g_mode)
      MODE_INC:  word = g_inc;
      MODE_LFSR: word = g_lfsr[k-1:0];
      MODE_WALK: word = g_walk;
      default:   word = g_pat;
    endcase
  end

  // Run control FSM, generator advance and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_INC;
      pat_q    <= '0;
      gap_q    <= '0;
      inc_q    <= '0;
      walk_q   <= k'(1);
      lfsr_q   <= SEED_EFF;
      tmr_q    <= '0;
      dout     <= '0;
      dvld     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      word_cnt <= '0;
    end else begin
      dvld <= emit;
      if (emit) begin
        dout     <= word;
        inc_q    <= g_inc + 1'b1;
        walk_q   <= (g_walk << 1) | (g_walk >> (k - 1));
        lfsr_q   <= LFSR_W'(lfsr_step(16'(g_lfsr)));
        word_cnt <= start_ok ? 16'd1 :
                    ((word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1);
      end
      if (start_ok) begin
        mode_q <= mode_t'(mode);
        pat_q  <= pattern;
        gap_q  <= gap;
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state_q <= ST_RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (last_word) begin
            state_q <= ST_DRAIN;
            tmr_q   <= 16'(DRAIN_LEN);
          end else if (gap_q != 4'd0) begin
            state_q <= ST_GAP;
            tmr_q   <= {12'd0, gap_q};
          end
        end
        ST_GAP: begin
          if (tmr_q == 16'd1) state_q <= ST_RUN;
          else                tmr_q   <= tmr_q - 16'd1;
        end
        ST_DRAIN: begin
          if (tmr_q == 16'd1) begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  hd_dly_line #(
    .W     (k + 1),
    .DEPTH (DEC_LAT)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst),
    .d     ({dvld, dout}),
    .q     (dly_q)
  );

  assign dvld_d = dly_q[k];
  assign din_d  = dly_q[k-1:0];

endmodule

// File: tb/tb_hd_data_gen.sv
// tb/tb_hd_data_gen.sv - self-checking bench for hd_data_gen
module tb_hd_data_gen;

  logic        clk;
  logic        rst;
  logic        start_a    [3];
  logic [1:0]  mode;
  logic [3:0]  pattern;
  logic [3:0]  gap;
  logic [3:0]  dout_a     [3];
  logic        dvld_a     [3];
  logic [3:0]  din_d_a    [3];
  logic        dvld_d_a   [3];
  logic        busy_a     [3];
  logic        done_a     [3];
  logic [15:0] word_cnt_a [3];

  int total;
  int bad;
  logic [3:0] got_q [$];

  typedef struct {
    int         inst;
    logic [1:0] m;
    logic [3:0] pat;
    logic [3:0] g;
    logic [3:0] w0;
    logic [3:0] w1;
    logic [3:0] w2;
    logic [3:0] w5;
  } vec_t;

  vec_t vecs [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hd_data_gen #(.k(4), .DEC_LAT(3), .SEED(16'hACE1), .NUM_WORDS(20)) u0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .mode(mode), .pattern(pattern), .gap(gap),
    .dout(dout_a[0]), .dvld(dvld_a[0]), .din_d(din_d_a[0]), .dvld_d(dvld_d_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .word_cnt(word_cnt_a[0]));

  hd_data_gen #(.k(4), .DEC_LAT(3), .SEED(16'h0000), .NUM_WORDS(0)) u1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .mode(mode), .pattern(pattern), .gap(gap),
    .dout(dout_a[1]), .dvld(dvld_a[1]), .din_d(din_d_a[1]), .dvld_d(dvld_d_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .word_cnt(word_cnt_a[1]));

  hd_data_gen #(.k(4), .DEC_LAT(0), .SEED(16'hACE1), .NUM_WORDS(6)) u2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .mode(mode), .pattern(pattern), .gap(gap),
    .dout(dout_a[2]), .dvld(dvld_a[2]), .din_d(din_d_a[2]), .dvld_d(dvld_d_a[2]),
    .busy(busy_a[2]), .done(done_a[2]), .word_cnt(word_cnt_a[2]));

  function automatic int lat_of(input int inst);
    return (inst == 2) ? 0 : 3;
  endfunction

  function automatic int numw_of(input int inst);
    case (inst)
      0:       return 20;
      1:       return 0;
      default: return 6;
    endcase
  endfunction

  function automatic logic [15:0] seed_of(input int inst);
    return (inst == 1) ? 16'h0001 : 16'hACE1;
  endfunction

  // Galois LFSR by its polynomial: divide by x, fold the x^-1 term back through the taps.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    if (s[0]) return (s >> 1) ^ 16'hB400;
    return s >> 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input int inst, input string tag);
    chk({tag, "_dout"},     32'(dout_a[inst]),     32'(0));
    chk({tag, "_dvld"},     32'(dvld_a[inst]),     32'(0));
    chk({tag, "_din_d"},    32'(din_d_a[inst]),    32'(0));
    chk({tag, "_dvld_d"},   32'(dvld_d_a[inst]),   32'(0));
    chk({tag, "_busy"},     32'(busy_a[inst]),     32'(0));
    chk({tag, "_done"},     32'(done_a[inst]),     32'(0));
    chk({tag, "_word_cnt"}, 32'(word_cnt_a[inst]), 32'(0));
  endtask

  // One full run: expected words from the pattern rules, timing from gap/latency arithmetic.
  task automatic do_run(input int inst, input logic [1:0] m, input logic [3:0] pat,
                        input logic [3:0] g, input int nexp, input bit poke);
    logic [3:0]  expq [$];
    logic [4:0]  hist [$];
    logic [15:0] s;
    int cyc, last_v, first_v, budget, lat, dlen;
    bit limited, fin;
    lat     = lat_of(inst);
    dlen    = (lat == 0) ? 1 : lat;
    limited = (numw_of(inst) != 0);
    s       = seed_of(inst);
    for (int i = 0; i < nexp; i++) begin
      case (m)
        2'd0:    expq.push_back(4'(i % 16));
        2'd1:    expq.push_back(s[3:0]);
        2'd2:    expq.push_back(4'(1 << (i % 4)));
        default: expq.push_back(pat);
      endcase
      s = lfsr_next(s);
    end
    got_q.delete();
    budget = nexp * (int'(g) + 1) + dlen + 20;
    @(posedge clk); #1;
    mode = m; pattern = pat; gap = g; start_a[inst] = 1'b1;
    @(posedge clk); #1;
    start_a[inst] = 1'b0;
    cyc = 0; last_v = -1; first_v = -1; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      hist.push_back({dvld_a[inst], dout_a[inst]});
      if (cyc >= lat)
        chk("delay_line", 32'({dvld_d_a[inst], din_d_a[inst]}), 32'(hist[cyc-lat]));
      if (dvld_a[inst]) begin
        if (first_v < 0) begin
          first_v = cyc;
          chk("first_latency", 32'(cyc), 32'(0));
        end else begin
          chk("word_spacing", 32'(cyc - last_v), 32'(int'(g) + 1));
        end
        if (got_q.size() < nexp)
          chk("word", 32'(dout_a[inst]), 32'(expq[got_q.size()]));
        got_q.push_back(dout_a[inst]);
        last_v = cyc;
      end
      if (poke) begin
        start_a[inst] = (cyc == 1 || cyc == 3);
        mode    = 2'd3;
        pattern = ~pat;
      end
      if (limited) begin
        if (done_a[inst]) begin
          chk("done_timing", 32'(cyc - last_v), 32'(dlen + 1));
          chk("word_total", 32'(got_q.size()), 32'(nexp));
          chk("word_cnt_final", 32'(word_cnt_a[inst]), 32'(nexp));
          chk("busy_in_done", 32'(busy_a[inst]), 32'(0));
          fin = 1'b1;
        end else begin
          chk("busy_in_run", 32'(busy_a[inst]), 32'(1));
        end
      end else begin
        chk("busy_unlimited", 32'(busy_a[inst]), 32'(1));
        if (got_q.size() == nexp) fin = 1'b1;
      end
      cyc++;
      if (!fin && cyc > budget) begin
        chk("run_timeout", 32'(cyc), 32'(budget));
        fin = 1'b1;
      end
    end
    start_a[inst] = 1'b0;
    if (limited) begin
      @(negedge clk);
      chk("hold_done", 32'(done_a[inst]), 32'(1));
      chk("hold_dvld", 32'(dvld_a[inst]), 32'(0));
      chk("hold_dout", 32'(dout_a[inst]), 32'(expq[nexp-1]));
      chk("hold_word_cnt", 32'(word_cnt_a[inst]), 32'(nexp));
    end
  endtask

  initial begin
    int         n;
    int         cyc;
    int         ri;
    logic [1:0] rm;
    logic [3:0] rp;
    logic [3:0] rg;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
    mode = 2'd0; pattern = 4'h0; gap = 4'd0;

    vecs[0] = '{0, 2'd0, 4'h0, 4'd0, 4'h0, 4'h1, 4'h2, 4'h5};
    vecs[1] = '{2, 2'd2, 4'h0, 4'd2, 4'h1, 4'h2, 4'h4, 4'h2};
    vecs[2] = '{0, 2'd3, 4'hA, 4'd1, 4'hA, 4'hA, 4'hA, 4'hA};
    vecs[3] = '{0, 2'd1, 4'h0, 4'd0, 4'h1, 4'h0, 4'h8, 4'h7};
    vecs[4] = '{2, 2'd0, 4'h0, 4'd3, 4'h0, 4'h1, 4'h2, 4'h5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_zero(i, "reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      do_run(vecs[v].inst, vecs[v].m, vecs[v].pat, vecs[v].g, numw_of(vecs[v].inst), 1'b0);
      if (got_q.size() > 5) begin
        chk("tbl_w0", 32'(got_q[0]), 32'(vecs[v].w0));
        chk("tbl_w1", 32'(got_q[1]), 32'(vecs[v].w1));
        chk("tbl_w2", 32'(got_q[2]), 32'(vecs[v].w2));
        chk("tbl_w5", 32'(got_q[5]), 32'(vecs[v].w5));
      end else begin
        chk("tbl_len", 32'(got_q.size()), 32'(6));
      end
    end

    // start pulses while in GAP and RUN must not disturb the run
    do_run(0, 2'd0, 4'h0, 4'd2, 20, 1'b1);

    // reset in the middle of a run, then a clean restart
    @(posedge clk); #1;
    mode = 2'd0; gap = 4'd0; start_a[0] = 1'b1;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    n = 0; cyc = 0;
    while (n < 7 && cyc < 50) begin
      @(negedge clk);
      if (dvld_a[0]) n++;
      cyc++;
    end
    chk("pre_reset_words", 32'(n), 32'(7));
    chk("pre_reset_dout", 32'(dout_a[0]), 32'(6));
    #2 rst = 1'b0;
    #1;
    chk_zero(0, "midrun");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_run(0, 2'd0, 4'h0, 4'd0, 20, 1'b0);
    if (got_q.size() > 0) chk("restart_w0", 32'(got_q[0]), 32'(0));
    else                  chk("restart_len", 32'(got_q.size()), 32'(20));

    // LFSR from a zero seed, unlimited run, 1000 words
    do_run(1, 2'd1, 4'h0, 4'd0, 1000, 1'b0);
    chk("unlimited_not_done", 32'(done_a[1]), 32'(0));
    @(negedge clk);
    chk("unlimited_still_issuing", 32'(dvld_a[1]), 32'(1));
    #2 rst = 1'b0;
    #1;
    chk_zero(1, "stop");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      ri = (r % 2 == 0) ? 0 : 2;
      rm = 2'($urandom_range(0, 3));
      rp = 4'($urandom);
      rg = 4'($urandom_range(0, 4));
      do_run(ri, rm, rp, rg, numw_of(ri), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hd_data_gen.md
Name: hd_data_gen

Overview:
- Stimulus source for the Hamming decoder sim environment. Produces k-bit data words with a valid strobe for the encoder/channel/decoder path.
- Also produces a copy of each word delayed by the decoder path latency, so the data checker sees the expected word in the same cycle as the decoder output.
- Start/stop-controlled FSM with selectable data patterns, inter-word gap pacing and a word budget.

Parameters:
k, 4, data word width (shared hd parameter); must be <= LFSR_W
DEC_LAT, 3, encoder-to-decoder pipeline latency in cycles; 0 means no delay
LFSR_W, 16, LFSR width
SEED, 16'hACE1, LFSR seed; a seed of 0 is replaced by 1
NUM_WORDS, 256, valid words per run; 0 means unlimited

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
start  input  1  single-cycle pulse; begins a run from IDLE or DONE
mode  input  2  0 increment, 1 LFSR, 2 walking-one, 3 fixed; sampled on start
pattern  input  k  fixed word for mode 3; sampled on start
gap  input  4  idle cycles between valid words; sampled on start
dout  output  k  word to the encoder
dvld  output  1  dout valid
din_d  output  k  dout delayed DEC_LAT cycles; goes to the checker
dvld_d  output  1  dvld delayed DEC_LAT cycles; goes to the checker
busy  output  1  high in RUN, GAP and DRAIN
done  output  1  high in DONE
word_cnt  output  16  valid words issued this run

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, delay line cleared, LFSR = SEED (or 1 if SEED is 0), counters 0. Reset asserted mid-run aborts the run immediately, with no drain.
- FSM states: IDLE, RUN, GAP, DRAIN, DONE. All outputs are registered.
- IDLE/DONE + start:
  - latch mode, pattern and gap; clear word_cnt; reinit the generator (inc=0, LFSR=seed, walk=1);
  - next cycle: RUN.
  - start in any other state is ignored.
- RUN: dvld=1 for exactly one cycle, dout = current generator word; the generator advances; word_cnt increments. Next state:
  - DRAIN if NUM_WORDS != 0 and the new word_cnt == NUM_WORDS;
  - else GAP if latched gap > 0 (gap counter loaded with gap);
  - else RUN (back-to-back words).
- GAP: dvld=0, dout holds its last value. Counter decrements each cycle; when it reaches 1, next state is RUN. Gap length is exactly gap cycles.
- DRAIN: dvld=0. Lasts DEC_LAT cycles so the delay line flushes; with DEC_LAT=0 it lasts one cycle. Then DONE.
- DONE: done=1, outputs hold, word_cnt frozen until the next start.
- Generators:
  - increment: wraps mod 2^k;
  - LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1, dout = lfsr[k-1:0];
  - walking-one: rotates left, bit k-1 wraps to bit 0;
  - fixed: latched pattern.
- Delay line: DEC_LAT-stage shift register of {dvld, dout}, shifting every cycle, including while dvld=0.
  - Invariant: dvld_d(t+DEC_LAT) = dvld(t) and din_d(t+DEC_LAT) = dout(t).
  - DEC_LAT=0 gives a combinational bypass.
- word_cnt saturates at 16'hFFFF in unlimited mode; words keep issuing.
- With NUM_WORDS=0 the run never ends (no DRAIN/DONE) and continues until reset.

Decomposition:
- Shared hd params package: k, DEC_LAT, LFSR polynomial constant, mode encodings (MODE_INC, MODE_LFSR, MODE_WALK, MODE_FIXED), FSM state encodings.
- One sub-module, hd_dly_line: parameterised width and depth shift register with async active-low reset and a DEC_LAT=0 bypass. Reused for any other latency-matching in the bench.

Test Plan:
- k=4, DEC_LAT=3, mode 0, gap 0, NUM_WORDS=20, start at cycle 5 -> dout 0,1,...,15,0,1,2,3 on 20 consecutive cycles; dvld_d/din_d identical 3 cycles later; done rises after 3 DRAIN cycles; word_cnt=20.
- Mode 2, gap 2, NUM_WORDS=6 -> dvld pattern 1,0,0 repeating; dout 0001,0010,0100,1000,0001,0010.
- Mode 1, SEED=0 -> LFSR runs from seed 1 and never produces an all-zero lock-up over 1000 words; sequence matches the reference model.
- Mid-run rst pulse at word 7 -> all outputs 0 in the same cycle as the rst fall; state IDLE; start afterwards restarts from word 0.
- start pulsed during RUN and GAP -> ignored; start in DONE -> new run with freshly latched mode 3, pattern 1010 giving a constant 1010 stream.
- DEC_LAT=0 -> din_d==dout and dvld_d==dvld every cycle; DRAIN lasts one cycle.
